// File: rtl/bitty_fetch.sv
// Instruction fetch/sequencer for the bitty core: local program RAM, PC, one-cycle
// run pulse per instruction, waits for done, halts on a sentinel or after LAST_ADDR.
module bitty_fetch #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] LAST_ADDR  = 8'hFF,
    parameter logic [15:0]       HALT_INSTR = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              done,
    output logic [15:0]       d_instr,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [15:0]       d_instr_next;
    logic              run_next;
    logic              load_ok;

    logic [15:0]       mem [DEPTH];
    logic [15:0]       rdata_p1;

    // Downloads are only accepted while the sequencer is not executing.
    assign load_ok = load_en && ((state == S_IDLE) || (state == S_HALT));

    // Program RAM: one write port, one registered read port addressed by pc in FETCH.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_addr] <= load_data;
        end
        if (state == S_FETCH) begin
            rdata_p1 <= mem[pc];
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        d_instr_next = d_instr;
        run_next     = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = '0;
                end
            end
            S_FETCH: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                // The sentinel is never handed to bitty; d_instr keeps the last issued word.
                if (rdata_p1 == HALT_INSTR) begin
                    state_next = S_HALT;
                end else begin
                    d_instr_next = rdata_p1;
                    run_next     = 1'b1;
                    state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done) begin
                    if (pc == LAST_ADDR) begin
                        state_next = S_HALT;
                    end else begin
                        pc_next    = pc + ADDR_W'(1);
                        state_next = S_FETCH;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            d_instr <= '0;
            run     <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            d_instr <= d_instr_next;
            run     <= run_next;
        end
    end

    assign busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT);
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_bitty_fetch.sv
// Directed self-checking bench for bitty_fetch (instance built with LAST_ADDR=3).
module tb_bitty_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic        done;
    logic [15:0] d_instr;
    logic        run;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;

    int errors = 0;
    int checks = 0;
    int run_count = 0;

    bitty_fetch #(
        .ADDR_W    (8),
        .LAST_ADDR (8'd3),
        .HALT_INSTR(16'hFFFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .done     (done),
        .d_instr  (d_instr),
        .run      (run),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Run pulses are tallied mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (run === 1'b1) run_count <= run_count + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Pulse start and/or done for one cycle (load_* may be preset by the caller),
    // then count cycles until run is seen, bounded.
    task automatic pulse_and_wait_run(input bit use_start, input bit use_done, output int n);
        if (use_start) start = 1'b1;
        if (use_done) done = 1'b1;
        step();
        start   = 1'b0;
        done    = 1'b0;
        load_en = 1'b0;
        n = 1;
        while (run !== 1'b1 && n < 12) begin
            step();
            n++;
        end
    endtask

    task automatic pulse_done_wait_halt(output int n);
        done = 1'b1;
        step();
        done = 1'b0;
        n = 1;
        while (halted !== 1'b1 && n < 12) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b expected 0", run); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (d_instr !== 16'h0000) begin errors++; $display("FAIL reset_d_instr: got %h expected 0000", d_instr); end
    endtask

    task automatic test_program();
        int n;
        int base;
        load_word(8'd0, 16'h1234);
        load_word(8'd1, 16'h5678);
        load_word(8'd2, 16'hFFFF);
        base = run_count;
        pulse_and_wait_run(1'b1, 1'b0, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL prog_start_latency: got %0d expected 3", n); end
        checks++; if (d_instr !== 16'h1234) begin errors++; $display("FAIL prog_instr0: got %h expected 1234", d_instr); end
        checks++; if (pc !== 8'd0) begin errors++; $display("FAIL prog_pc0: got %h expected 00", pc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL prog_busy: got %b expected 1", busy); end
        step();
        step();
        pulse_and_wait_run(1'b0, 1'b1, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL prog_done_latency: got %0d expected 3", n); end
        checks++; if (d_instr !== 16'h5678) begin errors++; $display("FAIL prog_instr1: got %h expected 5678", d_instr); end
        checks++; if (pc !== 8'd1) begin errors++; $display("FAIL prog_pc1: got %h expected 01", pc); end
        step();
        step();
        pulse_done_wait_halt(n);
        checks++; if (halted !== 1'b1 || n !== 3) begin errors++; $display("FAIL prog_halt: got halted=%b after %0d expected 1 after 3", halted, n); end
        checks++; if (pc !== 8'd2) begin errors++; $display("FAIL prog_halt_pc: got %h expected 02", pc); end
        checks++; if (d_instr !== 16'h5678) begin errors++; $display("FAIL prog_halt_instr: got %h expected 5678", d_instr); end
        step();
        checks++; if (run_count - base !== 2) begin errors++; $display("FAIL prog_run_count: got %0d expected 2", run_count - base); end
    endtask

    task automatic test_stall();
        int n;
        int base;
        bit stable;
        load_word(8'd0, 16'h1111);
        load_word(8'd1, 16'h2222);
        load_word(8'd2, 16'hFFFF);
        base = run_count;
        pulse_and_wait_run(1'b1, 1'b0, n);
        checks++; if (n !== 3 || d_instr !== 16'h1111) begin errors++; $display("FAIL stall_first: got n=%0d instr=%h expected 3 1111", n, d_instr); end
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (d_instr !== 16'h1111 || pc !== 8'd0 || run !== 1'b0 || busy !== 1'b1) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable: got instr=%h pc=%h run=%b expected 1111 00 0", d_instr, pc, run); end
        checks++; if (run_count - base !== 1) begin errors++; $display("FAIL stall_runs: got %0d expected 1", run_count - base); end
        pulse_and_wait_run(1'b0, 1'b1, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL stall_resume_latency: got %0d expected 3", n); end
        checks++; if (d_instr !== 16'h2222 || pc !== 8'd1) begin errors++; $display("FAIL stall_second: got %h pc=%h expected 2222 pc=01", d_instr, pc); end
        // done coincident with the run pulse is a zero-wait retire
        pulse_done_wait_halt(n);
        checks++; if (halted !== 1'b1 || n !== 3) begin errors++; $display("FAIL stall_zero_wait: got halted=%b after %0d expected 1 after 3", halted, n); end
        checks++; if (pc !== 8'd2) begin errors++; $display("FAIL stall_halt_pc: got %h expected 02", pc); end
    endtask

    task automatic test_last_addr();
        int n;
        int base;
        for (int i = 0; i < 4; i++) load_word(8'(i), 16'hA000 + 16'(i));
        load_word(8'd4, 16'hBEEF);
        base = run_count;
        for (int i = 0; i < 4; i++) begin
            pulse_and_wait_run(i == 0, i != 0, n);
            checks++; if (n !== 3 || d_instr !== 16'hA000 + 16'(i) || pc !== 8'(i)) begin
                errors++; $display("FAIL last_issue%0d: got n=%0d instr=%h pc=%h expected 3 %h %h", i, n, d_instr, pc, 16'hA000 + 16'(i), 8'(i));
            end
            step();
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++; if (halted !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL last_halt: got halted=%b busy=%b expected 1 0", halted, busy); end
        checks++; if (pc !== 8'd3) begin errors++; $display("FAIL last_pc: got %h expected 03", pc); end
        step();
        checks++; if (run_count - base !== 4) begin errors++; $display("FAIL last_runs: got %0d expected 4", run_count - base); end
        pulse_and_wait_run(1'b1, 1'b0, n);
        checks++; if (n !== 3 || pc !== 8'd0) begin errors++; $display("FAIL last_restart: got n=%0d pc=%h expected 3 00", n, pc); end
        checks++; if (d_instr !== 16'hA000 || halted !== 1'b0) begin errors++; $display("FAIL last_restart_instr: got %h halted=%b expected a000 0", d_instr, halted); end
    endtask

    task automatic test_busy_ignored();
        int n;
        int base;
        do_reset();
        load_word(8'd0, 16'h0101);
        load_word(8'd1, 16'h0202);
        load_word(8'd2, 16'hFFFF);
        base = run_count;
        pulse_and_wait_run(1'b1, 1'b0, n);
        checks++; if (n !== 3 || d_instr !== 16'h0101) begin errors++; $display("FAIL busy_first: got n=%0d instr=%h expected 3 0101", n, d_instr); end
        load_en   = 1'b1;
        load_addr = 8'd1;
        load_data = 16'hAAAA;
        start     = 1'b1;
        step();
        load_en = 1'b0;
        start   = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (busy !== 1'b1 || pc !== 8'd0 || d_instr !== 16'h0101) begin errors++; $display("FAIL busy_hold: got busy=%b pc=%h instr=%h expected 1 00 0101", busy, pc, d_instr); end
        checks++; if (run_count - base !== 1) begin errors++; $display("FAIL busy_start_ignored: got %0d runs expected 1", run_count - base); end
        pulse_and_wait_run(1'b0, 1'b1, n);
        checks++; if (n !== 3 || d_instr !== 16'h0202) begin errors++; $display("FAIL busy_load_dropped: got n=%0d instr=%h expected 3 0202", n, d_instr); end
        checks++; if (pc !== 8'd1) begin errors++; $display("FAIL busy_pc: got %h expected 01", pc); end
    endtask

    task automatic test_reset_in_wait();
        int n;
        int base;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (run !== 1'b0 || busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL rstwait_state: got run=%b busy=%b halted=%b expected 0 0 0", run, busy, halted); end
        checks++; if (pc !== 8'd0 || d_instr !== 16'h0000) begin errors++; $display("FAIL rstwait_regs: got pc=%h instr=%h expected 00 0000", pc, d_instr); end
        base = run_count;
        done = 1'b1;
        step();
        done = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++; if (busy !== 1'b0 || pc !== 8'd0) begin errors++; $display("FAIL rstwait_done_ignored: got busy=%b pc=%h expected 0 00", busy, pc); end
        checks++; if (run_count - base !== 0) begin errors++; $display("FAIL rstwait_no_run: got %0d runs expected 0", run_count - base); end
        load_en   = 1'b1;
        load_addr = 8'd0;
        load_data = 16'h0042;
        pulse_and_wait_run(1'b1, 1'b0, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL load_start_latency: got %0d expected 3", n); end
        checks++; if (d_instr !== 16'h0042 || pc !== 8'd0) begin errors++; $display("FAIL load_start_instr: got %h pc=%h expected 0042 00", d_instr, pc); end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        done      = 1'b0;
        test_reset();
        test_program();
        test_stall();
        test_last_addr();
        test_busy_ignored();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
